regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: ALU result (alu_*) and memory-load result (mem_*).
- Keeps an 8-bit scoreboard of registers with an outstanding write, so decode can detect RAW and WAW hazards.
- Sits between the execute/memory stages and the 8x16 register file (BA, A1-A3, D0-D3); drives its write_data, write_address and register_write inputs.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_write_arbiter_if.sv | 33 +++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/regfile_write_arbiter.sv | 87 ++++++++
 tb/tb_regfile_write_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Contents: word/address typedefs, register names of the 8x16 file, grant enum.
package regfile_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_BA = 3'd0;
  localparam reg_addr_t REG_A1 = 3'd1;
  localparam reg_addr_t REG_A2 = 3'd2;
  localparam reg_addr_t REG_A3 = 3'd3;
  localparam reg_addr_t REG_D0 = 3'd4;
  localparam reg_addr_t REG_D1 = 3'd5;
  localparam reg_addr_t REG_D2 = 3'd6;
  localparam reg_addr_t REG_D3 = 3'd7;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle for the two requesters (ALU result, memory load).
// master: requester side (drives valid/addr/data, receives ready).
// slave : arbiter side.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter (ALU vs MEM) with a last-grant flop.
// Ports: clk, rst_n, req_alu, req_mem in; gnt_alu_c, gnt_mem_c out (combinational).
// RR_EN=1 alternates on contention, RR_EN=0 gives MEM fixed priority.
module rr_arbiter2
  import regfile_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu_c,
  output logic gnt_mem_c
);

  grant_t last_grant;

  // A grant never asserts without its request; at most one grant per cycle.
  always_comb begin
    gnt_alu_c = 1'b0;
    gnt_mem_c = 1'b0;
    if (req_alu && req_mem) begin
      if (RR_EN && (last_grant == GNT_MEM)) gnt_alu_c = 1'b1;
      else                                  gnt_mem_c = 1'b1;
    end else begin
      gnt_alu_c = req_alu;
      gnt_mem_c = req_mem;
    end
  end

  // Reset to MEM so the ALU wins the first contention; only contention moves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_MEM;
    end else if (RR_EN && req_alu && req_mem) begin
      last_grant <= gnt_alu_c ? GNT_ALU : GNT_MEM;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between ALU and load writeback,
// and keeps a busy scoreboard of registers with an outstanding write.
// Ports: clk, rst_n; wb (slave: alu_*/mem_* handshakes); rsv_valid/rsv_addr
// (decode reservation); chk_addr1/2 (decode sources); hazard (combinational);
// busy (registered scoreboard); rf_write/rf_write_address/rf_write_data (to file).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter bit          RR_EN  = 1'b1,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_arbiter_if.slave wb,
  input  logic                  rsv_valid,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic [ADDR_W-1:0]     chk_addr1,
  input  logic [ADDR_W-1:0]     chk_addr2,
  output logic                  hazard,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  rf_write,
  output logic [ADDR_W-1:0]     rf_write_address,
  output logic [DATA_W-1:0]     rf_write_data
);

  logic                gnt_alu;
  logic                gnt_mem;
  logic                xfer;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [DATA_W-1:0]   xfer_data;
  logic [NUM_REGS-1:0] busy_nxt;

  rr_arbiter2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_alu   (wb.alu_valid),
    .req_mem   (wb.mem_valid),
    .gnt_alu_c (gnt_alu),
    .gnt_mem_c (gnt_mem)
  );

  assign wb.alu_ready = gnt_alu;
  assign wb.mem_ready = gnt_mem;

  // A grant implies its valid, so any grant is a transfer.
  assign xfer = gnt_alu | gnt_mem;

  // Payload of the granted requester.
  always_comb begin
    xfer_addr = wb.mem_addr;
    xfer_data = wb.mem_data;
    if (gnt_alu) begin
      xfer_addr = wb.alu_addr;
      xfer_data = wb.alu_data;
    end
  end

  // Clear on retire, then set on reserve so a fresh reservation wins a same-edge clash.
  always_comb begin
    busy_nxt = busy;
    if (xfer)      busy_nxt[xfer_addr] = 1'b0;
    if (rsv_valid) busy_nxt[rsv_addr]  = 1'b1;
  end

  assign hazard = busy[chk_addr1] | busy[chk_addr2] | (rsv_valid & busy[rsv_addr]);

  // One-cycle write stage; address/data hold when idle, reset drops a pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write         <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
      busy             <= '0;
    end else begin
      rf_write <= xfer;
      busy     <= busy_nxt;
      if (xfer) begin
        rf_write_address <= xfer_addr;
        rf_write_data    <= xfer_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench: two arbiters (round-robin and MEM-priority) driven by the same
// directed vectors, checked each cycle against a behavioural model, plus
// hand-computed literal expectations from the test plan.
module tb_regfile_write_arbiter;

  logic clk;
  logic rst_n;

  logic        av, mv, rv;
  logic [2:0]  aa, ma, ra, c1, c2;
  logic [15:0] ad, md;

  logic [1:0]  alu_rdy, mem_rdy, hz, rfw;
  logic [7:0]  bsy [2];
  logic [2:0]  rfa [2];
  logic [15:0] rfd [2];

  int n_cmp;
  int n_bad;

  // Behavioural model state per instance (0: round-robin, 1: MEM priority).
  // Grant codes: 0 none, 1 ALU, 2 MEM.
  int          m_last [2];
  logic [7:0]  m_busy [2];
  logic        m_rfw  [2];
  logic [2:0]  m_addr [2];
  logic [15:0] m_data [2];

  // Register file fed by instance 0's write port.
  logic [15:0] rf_mem [8];

  regfile_write_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus0 ();
  regfile_write_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();

  assign bus0.alu_valid = av;
  assign bus0.alu_addr  = aa;
  assign bus0.alu_data  = ad;
  assign bus0.mem_valid = mv;
  assign bus0.mem_addr  = ma;
  assign bus0.mem_data  = md;
  assign bus1.alu_valid = av;
  assign bus1.alu_addr  = aa;
  assign bus1.alu_data  = ad;
  assign bus1.mem_valid = mv;
  assign bus1.mem_addr  = ma;
  assign bus1.mem_data  = md;

  assign alu_rdy[0] = bus0.alu_ready;
  assign mem_rdy[0] = bus0.mem_ready;
  assign alu_rdy[1] = bus1.alu_ready;
  assign mem_rdy[1] = bus1.mem_ready;

  regfile_write_arbiter #(.RR_EN(1'b1), .DATA_W(16), .ADDR_W(3)) dut_rr (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb               (bus0.slave),
    .rsv_valid        (rv),
    .rsv_addr         (ra),
    .chk_addr1        (c1),
    .chk_addr2        (c2),
    .hazard           (hz[0]),
    .busy             (bsy[0]),
    .rf_write         (rfw[0]),
    .rf_write_address (rfa[0]),
    .rf_write_data    (rfd[0])
  );

  regfile_write_arbiter #(.RR_EN(1'b0), .DATA_W(16), .ADDR_W(3)) dut_fp (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb               (bus1.slave),
    .rsv_valid        (rv),
    .rsv_addr         (ra),
    .chk_addr1        (c1),
    .chk_addr2        (c2),
    .hazard           (hz[1]),
    .busy             (bsy[1]),
    .rf_write         (rfw[1]),
    .rf_write_address (rfa[1]),
    .rf_write_data    (rfd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Who wins this cycle, straight from the arbitration rules.
  function automatic int exp_grant(input logic a, input logic m, input logic rr, input int last);
    if (a && m) return (rr && last == 2) ? 1 : 2;
    if (a) return 1;
    if (m) return 2;
    return 0;
  endfunction

  function automatic logic [7:0] next_busy(input logic [7:0] b, input int g);
    logic [7:0] nb;
    nb = b;
    if (g == 1) nb[aa] = 1'b0;
    if (g == 2) nb[ma] = 1'b0;
    if (rv)     nb[ra] = 1'b1;
    return nb;
  endfunction

  // Reserving a busy register is legal only if that register retires on the same edge.
  function automatic logic rsv_clash(input logic [7:0] b, input int g);
    logic retiring;
    retiring = (g == 1 && aa == ra) || (g == 2 && ma == ra);
    return b[ra] && !retiring;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_last[i] <= 2;
        m_busy[i] <= 8'h00;
        m_rfw[i]  <= 1'b0;
        m_addr[i] <= 3'd0;
        m_data[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_rfw[i]  <= exp_grant(av, mv, i == 0, m_last[i]) != 0;
        m_busy[i] <= next_busy(m_busy[i], exp_grant(av, mv, i == 0, m_last[i]));
        if (exp_grant(av, mv, i == 0, m_last[i]) == 1) begin
          m_addr[i] <= aa;
          m_data[i] <= ad;
        end else if (exp_grant(av, mv, i == 0, m_last[i]) == 2) begin
          m_addr[i] <= ma;
          m_data[i] <= md;
        end
        if (av && mv) m_last[i] <= exp_grant(av, mv, i == 0, m_last[i]);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && rfw[0]) rf_mem[rfa[0]] <= rfd[0];
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("alu_ready[%0d]", i), 32'(alu_rdy[i]),
          32'(exp_grant(av, mv, i == 0, m_last[i]) == 1));
      chk($sformatf("mem_ready[%0d]", i), 32'(mem_rdy[i]),
          32'(exp_grant(av, mv, i == 0, m_last[i]) == 2));
      chk($sformatf("one_ready[%0d]", i), 32'(alu_rdy[i] & mem_rdy[i]), 32'd0);
      chk($sformatf("hazard[%0d]", i), 32'(hz[i]),
          32'(m_busy[i][c1] | m_busy[i][c2] | (rv & m_busy[i][ra])));
      chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(m_busy[i]));
      chk($sformatf("rf_write[%0d]", i), 32'(rfw[i]), 32'(m_rfw[i]));
      chk($sformatf("rf_addr[%0d]", i), 32'(rfa[i]), 32'(m_addr[i]));
      chk($sformatf("rf_data[%0d]", i), 32'(rfd[i]), 32'(m_data[i]));
    end
    if (rst_n && rv)
      chk("rsv_of_busy_reg", 32'(rsv_clash(m_busy[0], exp_grant(av, mv, 1'b1, m_last[0]))), 32'd0);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    av = 1'b0; mv = 1'b0; rv = 1'b0;
    aa = 3'd0; ma = 3'd0; ra = 3'd0; c1 = 3'd0; c2 = 3'd0;
    ad = 16'h0000; md = 16'h0000;
    for (int i = 0; i < 8; i++) rf_mem[i] <= 16'(16'hA000 + i);

    // Reset values
    repeat (2) @(posedge clk);
    mid();
    chk("reset_rf_write", 32'(rfw[0]), 32'd0);
    chk("reset_busy", 32'(bsy[0]), 32'h00);
    chk("reset_rf_addr", 32'(rfa[0]), 32'd0);
    chk("reset_rf_data", 32'(rfd[0]), 32'h0000);
    rst_n = 1'b1;
    nxt();

    // ALU only
    av = 1'b1; aa = 3'd5; ad = 16'h1234;
    mid();
    chk("alu_only_ready", 32'(alu_rdy[0]), 32'd1);
    nxt();
    av = 1'b0;
    mid();
    chk("alu_only_write", 32'(rfw[0]), 32'd1);
    chk("alu_only_addr", 32'(rfa[0]), 32'd5);
    chk("alu_only_data", 32'(rfd[0]), 32'h1234);
    nxt();
    mid();
    chk("alu_only_idle", 32'(rfw[0]), 32'd0);
    chk("rf_reg5", 32'(rf_mem[5]), 32'h1234);

    // Contention, four cycles
    nxt();
    av = 1'b1; aa = 3'd4; ad = 16'h4444;
    mv = 1'b1; ma = 3'd6; md = 16'h6666;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("rr_alu_ready", 32'(alu_rdy[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_mem_ready", 32'(mem_rdy[0]), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("fp_mem_ready", 32'(mem_rdy[1]), 32'd1);
      chk("fp_alu_ready", 32'(alu_rdy[1]), 32'd0);
      if (i > 0) chk("rr_addr_seq", 32'(rfa[0]), ((i - 1) % 2 == 0) ? 32'd4 : 32'd6);
      nxt();
    end
    av = 1'b0; mv = 1'b0;
    mid();
    chk("rr_addr_last", 32'(rfa[0]), 32'd6);
    chk("fp_addr_last", 32'(rfa[1]), 32'd6);

    // Scoreboard and hazard
    nxt();
    rv = 1'b1; ra = 3'd3;
    nxt();
    rv = 1'b0; c1 = 3'd3;
    mid();
    chk("sb_busy_set", 32'(bsy[0]), 32'h08);
    chk("sb_model_busy", 32'(m_busy[0]), 32'h08);
    chk("sb_hazard", 32'(hz[0]), 32'd1);
    nxt();
    mv = 1'b1; ma = 3'd3; md = 16'h3333;
    mid();
    chk("sb_mem_ready", 32'(mem_rdy[0]), 32'd1);
    nxt();
    mv = 1'b0;
    mid();
    chk("sb_busy_clr", 32'(bsy[0]), 32'h00);
    chk("sb_hazard_clr", 32'(hz[0]), 32'd0);

    // Simultaneous reserve and clear on reg 7
    nxt();
    c1 = 3'd0; rv = 1'b1; ra = 3'd7;
    nxt();
    av = 1'b1; aa = 3'd7; ad = 16'h7777;
    mid();
    chk("sim_busy_pre", 32'(bsy[0]), 32'h80);
    chk("sim_hazard", 32'(hz[0]), 32'd1);
    chk("sim_alu_ready", 32'(alu_rdy[0]), 32'd1);
    nxt();
    rv = 1'b0; av = 1'b0;
    mid();
    chk("sim_busy_kept", 32'(bsy[0]), 32'h80);
    chk("sim_addr", 32'(rfa[0]), 32'd7);
    nxt();
    av = 1'b1; aa = 3'd7; ad = 16'h7778;
    nxt();
    av = 1'b0;
    mid();
    chk("sim_busy_final", 32'(bsy[0]), 32'h00);

    // Async reset in the middle of a write
    nxt();
    rv = 1'b1; ra = 3'd2;
    nxt();
    rv = 1'b0; av = 1'b1; aa = 3'd2; ad = 16'hDEAD;
    mid();
    chk("rst_busy_pre", 32'(bsy[0]), 32'h04);
    chk("rst_alu_ready", 32'(alu_rdy[0]), 32'd1);
    nxt();
    av = 1'b0;
    chk("rst_pending_write", 32'(rfw[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_drop_write", 32'(rfw[0]), 32'd0);
    chk("rst_drop_busy", 32'(bsy[0]), 32'h00);
    chk("rst_drop_write_fp", 32'(rfw[1]), 32'd0);
    chk("rst_drop_busy_fp", 32'(bsy[1]), 32'h00);
    mid();
    nxt();
    mid();
    rst_n = 1'b1;
    nxt();
    mid();
    chk("rst_reg2_unchanged", 32'(rf_mem[2]), 32'hA002);
    chk("rst_idle_write", 32'(rfw[0]), 32'd0);

    repeat (2) nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
